// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store master: funct3 codes,
// FSM states and request decode helpers.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, RDATA, RESP} state_e;

  function automatic logic [2:0] nbytes(input logic [2:0] f3);
    case (f3[1:0])
      SB[1:0]: return 3'd1;
      SH[1:0]: return 3'd2;
      SW[1:0]: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

  // Sizes 11 and 110 do not exist; stores have no unsigned variants.
  function automatic logic illegal(input logic [2:0] f3, input logic wren);
    return (f3[1:0] == 2'b11) || (f3 == 3'b110) || (wren && f3[2]);
  endfunction

endpackage

// File: rtl/lsu_byte_master_if.sv
// Core request/response and byte-wide memory bus signals of lsu_byte_master.
interface lsu_byte_master_if #(parameter int ADDR_W = 16);
  logic              i_req_valid;
  logic              o_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_wren;
  logic [2:0]        i_req_funct3;
  logic [31:0]       i_req_wdata;
  logic              o_rsp_valid;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_err;
  logic              o_mem_req;
  logic              i_mem_gnt;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_we;
  logic [7:0]        o_mem_wdata;
  logic              i_mem_rvalid;
  logic [7:0]        i_mem_rdata;

  modport master (
    input  i_req_valid, i_req_addr, i_req_wren, i_req_funct3, i_req_wdata,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata
  );

  modport slave (
    output i_req_valid, i_req_addr, i_req_wren, i_req_funct3, i_req_wdata,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Turns the assembled load buffer into the architectural RV32 load result.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] buf_word,
  output logic [31:0] ext_word
);
  always_comb begin
    ext_word = '0;
    case (funct3)
      LB:      ext_word = {{24{buf_word[7]}}, buf_word[7:0]};
      LH:      ext_word = {{16{buf_word[15]}}, buf_word[15:0]};
      LW:      ext_word = buf_word;
      LBU:     ext_word = {24'd0, buf_word[7:0]};
      LHU:     ext_word = {16'd0, buf_word[15:0]};
      default: ext_word = '0;
    endcase
  end
endmodule

// File: rtl/lsu_byte_master.sv
// Splits one RV32 load/store into 1/2/4 byte transactions on a req/gnt/rvalid
// bus and returns the extended load word or an error.
module lsu_byte_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input logic               i_clk,
  input logic               i_rst_n,
  lsu_byte_master_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e            state;
  logic [ADDR_W-1:0] base;
  logic              wren;
  logic [2:0]        f3;
  logic [31:0]       wdata, rbuf, rbuf_nxt, ext;
  logic [1:0]        k, k1, last;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_done;

  logic              req_ready, rsp_valid, rsp_err, mem_req, mem_we;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  assign k1       = k + 2'd1;
  assign cnt_done = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Buffer as it will look once the byte on the bus this cycle is merged in.
  always_comb begin
    rbuf_nxt = rbuf;
    rbuf_nxt[{k, 3'b000} +: 8] = bus.i_mem_rdata;
  end

  lsu_load_extend u_ext (
    .funct3   (f3),
    .buf_word (rbuf_nxt),
    .ext_word (ext)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      base      <= '0;
      wren      <= 1'b0;
      f3        <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      k         <= '0;
      last      <= '0;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req_valid && req_ready) begin
            base      <= bus.i_req_addr;
            wren      <= bus.i_req_wren;
            f3        <= bus.i_req_funct3;
            wdata     <= bus.i_req_wdata;
            k         <= '0;
            last      <= 2'(nbytes(bus.i_req_funct3) - 3'd1);
            cnt       <= '0;
            rbuf      <= '0;
            req_ready <= 1'b0;
            if (illegal(bus.i_req_funct3, bus.i_req_wren)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_addr  <= bus.i_req_addr;
              mem_we    <= bus.i_req_wren;
              mem_wdata <= bus.i_req_wdata[7:0];
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        REQ: begin
          if (bus.i_mem_gnt) begin
            cnt <= '0;
            if (!wren) begin
              state   <= RDATA;
              mem_req <= 1'b0;
            end else if (k == last) begin
              state     <= RESP;
              mem_req   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= '0;
            end else begin
              // Back-to-back store bytes: req stays high, next byte presented.
              k         <= k1;
              mem_addr  <= base + ADDR_W'(k1);
              mem_wdata <= wdata[{k1, 3'b000} +: 8];
            end
          end else if (cnt_done) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RDATA: begin
          if (bus.i_mem_rvalid) begin
            rbuf <= rbuf_nxt;
            cnt  <= '0;
            if (k == last) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= ext;
            end else begin
              state     <= REQ;
              k         <= k1;
              mem_req   <= 1'b1;
              mem_addr  <= base + ADDR_W'(k1);
              mem_wdata <= wdata[{k1, 3'b000} +: 8];
            end
          end else if (cnt_done) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = req_ready;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_rdata = rsp_rdata;
  assign bus.o_rsp_err   = rsp_err;
  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_wdata = mem_wdata;

endmodule

// File: tb/tb_lsu_byte_master.sv
// Bench for lsu_byte_master: vector table, hand-written reset/wrap sequences
// and random transactions against a byte-array memory model.
module tb_lsu_byte_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_byte_master_if #(.ADDR_W(16)) bus ();

  lsu_byte_master #(.ADDR_W(16), .TIMEOUT_CYC(64)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] mem [0:65535];

  typedef struct {
    logic [15:0] a;
    logic        we;
    logic [7:0]  d;
  } acc_t;
  acc_t acc_q[$];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          req_hi;
  } res_t;

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic        wren;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] gdly;   // grant delay per byte, byte k in bits [8k+7:8k]; FF = never
    int          rdly;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_req_hi;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one request and act as the memory until the response pulse.
  task automatic run(input logic [15:0] addr, input logic wren, input logic [2:0] f3,
                     input logic [31:0] wdata, input logic [31:0] gdly, input int rdly,
                     output res_t r);
    int c, waited, rvc, bi;
    bit pend;
    logic [15:0] pa, prev_a;
    logic [7:0] prev_d;
    acc_q.delete();
    r.rdata = '0; r.err = 1'b0; r.lat = -1; r.req_hi = 0;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_addr = addr; bus.i_req_wren = wren;
    bus.i_req_funct3 = f3; bus.i_req_wdata = wdata;
    c = 0;
    while (!bus.o_req_ready && c < 50) begin @(negedge clk); c++; end
    check("ready_idle", bus.o_req_ready, 1'b1);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    c = 0; waited = 0; rvc = 0; bi = 0; pend = 0; pa = '0; prev_a = '0; prev_d = '0;
    while (c < 400) begin
      @(negedge clk); c++;
      bus.i_mem_gnt = 1'b0; bus.i_mem_rvalid = 1'b0;
      if (bus.o_rsp_valid) begin
        r.rdata = bus.o_rsp_rdata; r.err = bus.o_rsp_err; r.lat = c;
        break;
      end
      if (pend) begin
        if (rvc >= rdly) begin
          bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = mem[pa]; pend = 0;
        end else rvc++;
      end
      if (bus.o_mem_req) begin
        r.req_hi++;
        if (waited > 0) begin
          check("req_stable_addr", bus.o_mem_addr, prev_a);
          if (wren) check("req_stable_wdata", bus.o_mem_wdata, prev_d);
        end
        prev_a = bus.o_mem_addr; prev_d = bus.o_mem_wdata;
        if (bi < 4 && waited >= int'(gdly[8*bi +: 8])) begin
          bus.i_mem_gnt = 1'b1;
          acc_q.push_back('{bus.o_mem_addr, bus.o_mem_we, bus.o_mem_wdata});
          if (bus.o_mem_we) mem[bus.o_mem_addr] = bus.o_mem_wdata;
          else begin pend = 1; rvc = 0; pa = bus.o_mem_addr; end
          bi++; waited = 0;
        end else waited++;
      end
    end
    @(negedge clk);
    check("rsp_one_cycle", bus.o_rsp_valid, 1'b0);
    check("ready_after_rsp", bus.o_req_ready, 1'b1);
  endtask

  task automatic check_acc(input string tag, input logic [15:0] addr, input logic wren,
                           input logic [31:0] wdata, input int n);
    check({tag, "_nacc"}, acc_q.size(), n);
    for (int i = 0; i < n && i < acc_q.size(); i++) begin
      check({tag, "_addr"}, acc_q[i].a, 16'(addr + i));
      check({tag, "_we"}, acc_q[i].we, wren);
      if (wren) check({tag, "_wd"}, acc_q[i].d, wdata[8*i +: 8]);
    end
  endtask

  // Reference: what the core should see, computed from the memory contents.
  task automatic model(input logic [15:0] addr, input logic wren, input logic [2:0] f3,
                       input logic [31:0] gdly, input int rdly,
                       output logic [31:0] rd, output logic err, output int lat, output int n);
    longint v;
    bit is_signed;
    err = (f3[1:0] == 2'b11) || (f3 == 3'b110) || (wren && f3[2]);
    rd = '0; lat = 1; n = 0;
    if (err) return;
    n = 1 << f3[1:0];
    is_signed = (f3[2] == 1'b0) && (n < 4);
    v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(mem[16'(addr + i)]);
    if (is_signed && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
    if (!wren) rd = 32'(v);
    for (int i = 0; i < n; i++) lat += int'(gdly[8*i +: 8]) + 1 + (wren ? 0 : rdly + 1);
  endtask

  vec_t vecs[$];
  res_t r;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] erd, wd, gd;
    logic        eerr, wr;
    logic [15:0] ad;
    logic [2:0]  f;
    int          elat, en, rl;

    vecs.push_back('{"lb_neg",    16'h2003, 1'b0, 3'b000, 32'h0,         32'h0,         0, 32'hFFFF_FF80, 1'b0, 3,  1});
    vecs.push_back('{"lbu",       16'h2003, 1'b0, 3'b100, 32'h0,         32'h0,         0, 32'h0000_0080, 1'b0, 3,  1});
    vecs.push_back('{"lhu_mis",   16'h2001, 1'b0, 3'b101, 32'h0,         32'h0,         0, 32'h0000_F234, 1'b0, 5,  2});
    vecs.push_back('{"lh_neg",    16'h3000, 1'b0, 3'b001, 32'h0,         32'h0,         0, 32'hFFFF_8000, 1'b0, 5,  2});
    vecs.push_back('{"lw_slowrv", 16'h4000, 1'b0, 3'b010, 32'h0,         32'h0,         2, 32'h4433_2211, 1'b0, 17, 4});
    vecs.push_back('{"sh_slowg",  16'h6001, 1'b1, 3'b001, 32'h1234_5678, 32'h0000_0002, 0, 32'h0,         1'b0, 5,  4});
    vecs.push_back('{"ill_011",   16'h1000, 1'b0, 3'b011, 32'h0,         32'h0,         0, 32'h0,         1'b1, 1,  0});
    vecs.push_back('{"ill_110",   16'h1000, 1'b0, 3'b110, 32'h0,         32'h0,         0, 32'h0,         1'b1, 1,  0});
    vecs.push_back('{"ill_sb100", 16'h1000, 1'b1, 3'b100, 32'hAA,        32'h0,         0, 32'h0,         1'b1, 1,  0});
    vecs.push_back('{"lw_tmo",    16'h7000, 1'b0, 3'b010, 32'h0,         32'hFFFF_FFFF, 0, 32'h0,         1'b1, 65, 64});

    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3) ^ 8'(i >> 8);
    mem[16'h2003] = 8'h80;
    mem[16'h2001] = 8'h34; mem[16'h2002] = 8'hF2;
    mem[16'h3000] = 8'h00; mem[16'h3001] = 8'h80;
    mem[16'h4000] = 8'h11; mem[16'h4001] = 8'h22; mem[16'h4002] = 8'h33; mem[16'h4003] = 8'h44;

    bus.i_req_valid = 1'b0; bus.i_req_addr = '0; bus.i_req_wren = 1'b0;
    bus.i_req_funct3 = '0; bus.i_req_wdata = '0;
    bus.i_mem_gnt = 1'b0; bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = '0;

    // Reset state
    #2;
    check("rst_ready", bus.o_req_ready, 1'b0);
    check("rst_mem_req", bus.o_mem_req, 1'b0);
    check("rst_rsp_valid", bus.o_rsp_valid, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", bus.o_req_ready, 1'b0);
    @(negedge clk);
    check("ready_after_edge", bus.o_req_ready, 1'b1);

    foreach (vecs[i]) begin
      run(vecs[i].addr, vecs[i].wren, vecs[i].f3, vecs[i].wdata, vecs[i].gdly, vecs[i].rdly, r);
      check({vecs[i].name, "_rdata"}, r.rdata, vecs[i].exp_rd);
      check({vecs[i].name, "_err"}, r.err, vecs[i].exp_err);
      check({vecs[i].name, "_lat"}, r.lat, vecs[i].exp_lat);
      check({vecs[i].name, "_reqhi"}, r.req_hi, vecs[i].exp_req_hi);
      if (!vecs[i].exp_err)
        check_acc(vecs[i].name, vecs[i].addr, vecs[i].wren, vecs[i].wdata, 1 << vecs[i].f3[1:0]);
      else
        check({vecs[i].name, "_nacc"}, acc_q.size(), 0);
    end

    // SW across the top of the address space, byte 1 held off for 3 cycles
    run(16'hFFFE, 1'b1, 3'b010, 32'hDEAD_BEEF, 32'h0000_0300, 0, r);
    check("sw_wrap_err", r.err, 1'b0);
    check("sw_wrap_lat", r.lat, 8);
    check("sw_wrap_nacc", acc_q.size(), 4);
    if (acc_q.size() == 4) begin
      check("sw_wrap_a0", acc_q[0].a, 16'hFFFE); check("sw_wrap_d0", acc_q[0].d, 8'hEF);
      check("sw_wrap_a1", acc_q[1].a, 16'hFFFF); check("sw_wrap_d1", acc_q[1].d, 8'hBE);
      check("sw_wrap_a2", acc_q[2].a, 16'h0000); check("sw_wrap_d2", acc_q[2].d, 8'hAD);
      check("sw_wrap_a3", acc_q[3].a, 16'h0001); check("sw_wrap_d3", acc_q[3].d, 8'hDE);
    end

    // Reset while waiting for grant: req must fall without a clock edge
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_addr = 16'h5000; bus.i_req_wren = 1'b0; bus.i_req_funct3 = 3'b010;
    @(posedge clk); #1 bus.i_req_valid = 1'b0;
    @(negedge clk);
    check("mid_req_high", bus.o_mem_req, 1'b1);
    rst_n = 1'b0;
    #1 check("rst_req_drop", bus.o_mem_req, 1'b0);
    check("rst_req_ready", bus.o_req_ready, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Reset during RDATA of LW; later rvalid must be ignored
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    @(posedge clk); #1 bus.i_req_valid = 1'b0;
    @(negedge clk); bus.i_mem_gnt = 1'b1;
    @(negedge clk); bus.i_mem_gnt = 1'b0;
    check("rdata_req_low", bus.o_mem_req, 1'b0);
    rst_n = 1'b0;
    #1 check("rst_rdata_rsp", bus.o_rsp_valid, 1'b0);
    check("rst_rdata_ready", bus.o_req_ready, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_rv_no_rsp", bus.o_rsp_valid, 1'b0);
      check("stray_rv_no_req", bus.o_mem_req, 1'b0);
    end
    check("stray_rv_ready", bus.o_req_ready, 1'b1);
    bus.i_mem_rvalid = 1'b0;

    run(16'h2003, 1'b0, 3'b000, 32'h0, 32'h0, 0, r);
    check("post_rst_lb", r.rdata, 32'hFFFF_FF80);
    check("post_rst_lat", r.lat, 3);

    // Random transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      ad = 16'($urandom);
      wr = 1'($urandom);
      f  = 3'($urandom_range(7));
      wd = $urandom;
      gd = {8'($urandom_range(2)), 8'($urandom_range(2)), 8'($urandom_range(2)), 8'($urandom_range(2))};
      rl = int'($urandom_range(2));
      model(ad, wr, f, gd, rl, erd, eerr, elat, en);
      run(ad, wr, f, wd, gd, rl, r);
      check("rnd_rdata", r.rdata, erd);
      check("rnd_err", r.err, eerr);
      check("rnd_lat", r.lat, elat);
      check_acc("rnd", ad, wr, wd, en);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
